// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter between the
// pipeline MEM stage and the debug/loader port.
package dmem_arbiter_pkg;

    // Arbiter ownership state: CPU-priority arbitration or debugger-owned.
    typedef enum logic {
        ARB_CPU      = 1'b0,
        ARB_DBG_LOCK = 1'b1
    } arb_state_t;

    // One memory access request; the same shape is used for both ports.
    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  width;
    } dmem_req_t;

    // Byte address falls inside the data memory (compared at 32 bits).
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/dmem_arbiter_checker.sv
// Protocol properties of the data-memory arbiter outputs.
module dmem_arbiter_checker (
    input logic clk,
    input logic rst_n,
    input logic cpu_req,
    input logic cpu_gnt,
    input logic cpu_stall,
    input logic dbg_gnt
);

    // Only one port may own the memory in any cycle.
    a_one_hot_gnt: assert property (@(posedge clk) disable iff (!rst_n)
        !(cpu_gnt && dbg_gnt));

    // Stall is exactly a pending, ungranted CPU request.
    a_stall_def: assert property (@(posedge clk) disable iff (!rst_n)
        cpu_stall == (cpu_req && !cpu_gnt));

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares the single-port data memory between the CPU
// MEM stage and the debug/loader port. CPU has default priority, a
// starvation counter forces DBG ahead after STARVE_LIMIT denied cycles,
// and a DBG lock keeps memory with the debugger across multi-cycle
// sequences. Grants are combinational so load data returns in the grant
// cycle.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned DMEM_DEPTH   = 4096,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_width,
    output logic        cpu_gnt,
    output logic        cpu_stall,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    input  logic [2:0]  dbg_width,
    input  logic        dbg_lock,
    output logic        dbg_gnt,
    output logic        dbg_err,
    output logic [31:0] dbg_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_width,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] DEPTH_C     = 32'(DMEM_DEPTH);
    localparam logic [7:0]  STARVE_LIM_C = 8'(STARVE_LIMIT);

    arb_state_t  state_r;
    arb_state_t  state_nxt_s;
    logic [7:0]  starve_cnt_r;
    logic [7:0]  starve_cnt_nxt_s;
    dmem_req_t   cpu_s;
    dmem_req_t   dbg_s;
    logic        cpu_gnt_s;
    logic        dbg_gnt_s;
    logic        cpu_in_range_s;
    logic        dbg_in_range_s;
    logic        sel_we_s;
    logic        sel_in_range_s;

    assign cpu_s = '{req: cpu_req, we: cpu_we, addr: cpu_addr,
                     wdata: cpu_wdata, width: cpu_width};
    assign dbg_s = '{req: dbg_req, we: dbg_we, addr: dbg_addr,
                     wdata: dbg_wdata, width: dbg_width};

    assign cpu_in_range_s = addr_in_range(cpu_s.addr, DEPTH_C);
    assign dbg_in_range_s = addr_in_range(dbg_s.addr, DEPTH_C);

    // Grant decision; reset forces both grants low so no strobe can fire.
    always_comb begin
        cpu_gnt_s = 1'b0;
        dbg_gnt_s = 1'b0;
        if (!rst_n) begin
            cpu_gnt_s = 1'b0;
            dbg_gnt_s = 1'b0;
        end else begin
            case (state_r)
                ARB_CPU: begin
                    if (dbg_s.req && (!cpu_s.req || (starve_cnt_r == STARVE_LIM_C))) begin
                        dbg_gnt_s = 1'b1;
                    end else if (cpu_s.req) begin
                        cpu_gnt_s = 1'b1;
                    end else begin
                        cpu_gnt_s = 1'b0;
                    end
                end
                ARB_DBG_LOCK: begin
                    if (dbg_s.req) begin
                        dbg_gnt_s = 1'b1;
                    end else begin
                        dbg_gnt_s = 1'b0;
                    end
                end
                default: begin
                    cpu_gnt_s = 1'b0;
                    dbg_gnt_s = 1'b0;
                end
            endcase
        end
    end

    // Next ownership state: enter lock on a locked DBG grant, leave when
    // DBG drops the request or the lock (that cycle's access still runs).
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ARB_CPU: begin
                if (dbg_gnt_s && dbg_lock) begin
                    state_nxt_s = ARB_DBG_LOCK;
                end else begin
                    state_nxt_s = ARB_CPU;
                end
            end
            ARB_DBG_LOCK: begin
                if (dbg_s.req && dbg_lock) begin
                    state_nxt_s = ARB_DBG_LOCK;
                end else begin
                    state_nxt_s = ARB_CPU;
                end
            end
            default: state_nxt_s = ARB_CPU;
        endcase
    end

    // Starvation counter: counts consecutive denied DBG cycles, saturating.
    always_comb begin
        starve_cnt_nxt_s = 8'd0;
        if (state_r == ARB_DBG_LOCK) begin
            starve_cnt_nxt_s = 8'd0;
        end else if (dbg_s.req && !dbg_gnt_s) begin
            if (starve_cnt_r < STARVE_LIM_C) begin
                starve_cnt_nxt_s = starve_cnt_r + 8'd1;
            end else begin
                starve_cnt_nxt_s = starve_cnt_r;
            end
        end else begin
            starve_cnt_nxt_s = 8'd0;
        end
    end

    // State and counter registers; reset drops any held DBG lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ARB_CPU;
            starve_cnt_r <= 8'd0;
        end else begin
            state_r      <= state_nxt_s;
            starve_cnt_r <= starve_cnt_nxt_s;
        end
    end

    // Memory mux (CPU drives the bus when idle) and gated strobes.
    always_comb begin
        if (dbg_gnt_s) begin
            mem_addr       = dbg_s.addr;
            mem_wdata      = dbg_s.wdata;
            mem_width      = dbg_s.width;
            sel_we_s       = dbg_s.we;
            sel_in_range_s = dbg_in_range_s;
        end else begin
            mem_addr       = cpu_s.addr;
            mem_wdata      = cpu_s.wdata;
            mem_width      = cpu_s.width;
            sel_we_s       = cpu_s.we;
            sel_in_range_s = cpu_in_range_s;
        end
        mem_read  = (cpu_gnt_s || dbg_gnt_s) && !sel_we_s && sel_in_range_s;
        mem_write = (cpu_gnt_s || dbg_gnt_s) && sel_we_s && sel_in_range_s;
    end

    // Per-port status and read data; out-of-range loads return zero.
    always_comb begin
        cpu_gnt   = cpu_gnt_s;
        dbg_gnt   = dbg_gnt_s;
        cpu_stall = rst_n && cpu_s.req && !cpu_gnt_s;
        cpu_err   = cpu_gnt_s && !cpu_in_range_s;
        dbg_err   = dbg_gnt_s && !dbg_in_range_s;
        if (cpu_gnt_s && !cpu_s.we && cpu_in_range_s) begin
            cpu_rdata = mem_rdata;
        end else begin
            cpu_rdata = 32'h0000_0000;
        end
        if (dbg_gnt_s && !dbg_s.we && dbg_in_range_s) begin
            dbg_rdata = mem_rdata;
        end else begin
            dbg_rdata = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a word-wide behavioural data memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [2:0]  cpu_width;
    logic        cpu_gnt, cpu_stall, cpu_err;
    logic [31:0] cpu_rdata;
    logic        dbg_req, dbg_we, dbg_lock;
    logic [31:0] dbg_addr, dbg_wdata;
    logic [2:0]  dbg_width;
    logic        dbg_gnt, dbg_err;
    logic [31:0] dbg_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_width;
    logic        mem_read, mem_write;

    logic [31:0] mem_q [0:1023];

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DMEM_DEPTH(4096), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_width(cpu_width),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_err(cpu_err),
        .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_width(dbg_width), .dbg_lock(dbg_lock),
        .dbg_gnt(dbg_gnt), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_width(mem_width),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    dmem_arbiter_checker u_chk (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_gnt(cpu_gnt),
        .cpu_stall(cpu_stall), .dbg_gnt(dbg_gnt)
    );

    // Combinational-read, clocked-write data memory (addresses alias mod 4 KiB).
    assign mem_rdata = mem_q[mem_addr[11:2]];
    always @(posedge clk) begin
        if (mem_write) mem_q[mem_addr[11:2]] <= mem_wdata;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_width = 3'b010;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'h0; dbg_wdata = 32'h0; dbg_width = 3'b010;
        dbg_lock = 1'b0;
    endtask

    task automatic cpu_drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    endtask

    task automatic dbg_drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic lock);
        dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_lock = lock;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        cpu_drive(1'b1, 32'h10, 32'h1);
        dbg_drive(1'b1, 32'h20, 32'h2, 1'b1);
        #2;
        checks++;
        if ({cpu_gnt, dbg_gnt, cpu_stall, cpu_err, dbg_err, mem_read, mem_write} !== 7'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {cpu_gnt, dbg_gnt, cpu_stall, cpu_err, dbg_err, mem_read, mem_write});
        end
        idle();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_cpu_load();
        // preload two words via DBG
        dbg_drive(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        step();
        dbg_drive(1'b1, 32'h0, 32'hCAFEF00D, 1'b0);
        step();
        idle();
        cpu_drive(1'b0, 32'h10, 32'h0);
        @(negedge clk);
        checks++;
        if ({cpu_gnt, cpu_stall, mem_read, cpu_rdata} !== {3'b101, 32'hDEADBEEF}) begin
            fails++;
            $display("FAIL cpu_load: gnt/stall/rd=%b%b%b rdata=%h expected 101 deadbeef",
                     cpu_gnt, cpu_stall, mem_read, cpu_rdata);
        end
        step();
        idle();
    endtask

    task automatic test_dbg_write();
        dbg_drive(1'b1, 32'h20, 32'h12345678, 1'b0);
        @(negedge clk);
        checks++;
        if ({dbg_gnt, cpu_gnt, mem_write, mem_read, mem_addr} !== {4'b1010, 32'h20}) begin
            fails++;
            $display("FAIL dbg_write: gnt/cgnt/wr/rd=%b%b%b%b addr=%h expected 1010 00000020",
                     dbg_gnt, cpu_gnt, mem_write, mem_read, mem_addr);
        end
        step();
        idle();
        cpu_drive(1'b0, 32'h20, 32'h0);
        @(negedge clk);
        checks++;
        if ({cpu_gnt, cpu_rdata} !== {1'b1, 32'h12345678}) begin
            fails++;
            $display("FAIL dbg_write_readback: gnt=%b rdata=%h expected 1 12345678", cpu_gnt, cpu_rdata);
        end
        step();
        idle();
        step();
    endtask

    task automatic test_starvation();
        logic exp_dbg;
        cpu_drive(1'b0, 32'h10, 32'h0);
        dbg_drive(1'b0, 32'h20, 32'h0, 1'b0);
        for (int i = 1; i <= 18; i++) begin
            exp_dbg = ((i % 9) == 0);
            @(negedge clk);
            checks++;
            if ({cpu_gnt, dbg_gnt, cpu_stall} !== {!exp_dbg, exp_dbg, exp_dbg}) begin
                fails++;
                $display("FAIL starve_cycle%0d: cgnt/dgnt/stall=%b%b%b expected %b%b%b",
                         i, cpu_gnt, dbg_gnt, cpu_stall, !exp_dbg, exp_dbg, exp_dbg);
            end
            if (exp_dbg) begin
                checks++;
                if ({dbg_rdata, cpu_rdata} !== {32'h12345678, 32'h0}) begin
                    fails++;
                    $display("FAIL starve_rdata%0d: dbg=%h cpu=%h expected 12345678 00000000",
                             i, dbg_rdata, cpu_rdata);
                end
            end
            step();
        end
        idle();
        step();
    endtask

    task automatic test_lock();
        int waited = 0;
        bit got = 1'b0;
        cpu_drive(1'b0, 32'h38, 32'h0);
        dbg_drive(1'b1, 32'h30, 32'h11111111, 1'b1);
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (dbg_gnt) begin
                got = 1'b1;
                break;
            end
            waited++;
            step();
        end
        checks++;
        if (!got || waited != 8) begin
            fails++;
            $display("FAIL lock_first_grant: granted=%0d after %0d denied cycles expected 1 after 8",
                     got, waited);
        end
        for (int k = 0; k < 3; k++) begin
            if (k == 1) dbg_drive(1'b1, 32'h34, 32'h22222222, 1'b1);
            if (k == 2) dbg_drive(1'b1, 32'h38, 32'h33333333, 1'b0);
            if (k > 0) @(negedge clk);
            checks++;
            if ({dbg_gnt, cpu_gnt, cpu_stall, mem_write} !== 4'b1011) begin
                fails++;
                $display("FAIL lock_write%0d: dgnt/cgnt/stall/wr=%b%b%b%b expected 1011",
                         k, dbg_gnt, cpu_gnt, cpu_stall, mem_write);
            end
            step();
        end
        dbg_req = 1'b0; dbg_lock = 1'b0;
        @(negedge clk);
        checks++;
        if ({cpu_gnt, cpu_stall, cpu_rdata} !== {2'b10, 32'h33333333}) begin
            fails++;
            $display("FAIL lock_release: cgnt/stall=%b%b rdata=%h expected 10 33333333",
                     cpu_gnt, cpu_stall, cpu_rdata);
        end
        step();
        idle();
        step();
    endtask

    task automatic test_out_of_range();
        cpu_drive(1'b1, 32'h1000, 32'hBADBAD00);
        @(negedge clk);
        checks++;
        if ({cpu_gnt, cpu_err, mem_write, cpu_stall} !== 4'b1100) begin
            fails++;
            $display("FAIL oor_store: gnt/err/wr/stall=%b%b%b%b expected 1100",
                     cpu_gnt, cpu_err, mem_write, cpu_stall);
        end
        step();
        cpu_drive(1'b0, 32'h1000, 32'h0);
        @(negedge clk);
        checks++;
        if ({cpu_gnt, cpu_err, mem_read, cpu_rdata} !== {3'b110, 32'h0}) begin
            fails++;
            $display("FAIL oor_load: gnt/err/rd=%b%b%b rdata=%h expected 110 00000000",
                     cpu_gnt, cpu_err, mem_read, cpu_rdata);
        end
        step();
        cpu_drive(1'b0, 32'hFFC, 32'h0);
        @(negedge clk);
        checks++;
        if ({cpu_gnt, cpu_err, mem_read} !== 3'b101) begin
            fails++;
            $display("FAIL last_word_in_range: gnt/err/rd=%b%b%b expected 101", cpu_gnt, cpu_err, mem_read);
        end
        step();
        cpu_drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (cpu_rdata !== 32'hCAFEF00D) begin
            fails++;
            $display("FAIL oor_mem_unchanged: rdata=%h expected cafef00d", cpu_rdata);
        end
        step();
        idle();
        dbg_drive(1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0);
        @(negedge clk);
        checks++;
        if ({dbg_gnt, dbg_err, mem_read, dbg_rdata} !== {3'b110, 32'h0}) begin
            fails++;
            $display("FAIL dbg_oor_load: gnt/err/rd=%b%b%b rdata=%h expected 110 00000000",
                     dbg_gnt, dbg_err, mem_read, dbg_rdata);
        end
        step();
        idle();
    endtask

    task automatic test_reset_mid_lock();
        dbg_drive(1'b1, 32'h50, 32'h55555555, 1'b1);
        step();
        cpu_drive(1'b0, 32'h10, 32'h0);
        @(negedge clk);
        checks++;
        if ({dbg_gnt, cpu_gnt, cpu_stall} !== 3'b101) begin
            fails++;
            $display("FAIL in_lock: dgnt/cgnt/stall=%b%b%b expected 101", dbg_gnt, cpu_gnt, cpu_stall);
        end
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cpu_gnt, dbg_gnt, cpu_stall, cpu_err, dbg_err, mem_read, mem_write} !== 7'b0) begin
            fails++;
            $display("FAIL reset_mid_lock: got %b expected 0000000",
                     {cpu_gnt, dbg_gnt, cpu_stall, cpu_err, dbg_err, mem_read, mem_write});
        end
        dbg_req = 1'b0; dbg_lock = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({cpu_gnt, cpu_stall, cpu_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            fails++;
            $display("FAIL after_reset_cpu: gnt/stall=%b%b rdata=%h expected 10 deadbeef",
                     cpu_gnt, cpu_stall, cpu_rdata);
        end
        step();
        idle();
    endtask

    initial begin
        test_reset();
        test_cpu_load();
        test_dbg_write();
        test_starvation();
        test_lock();
        test_out_of_range();
        test_reset_mid_lock();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
